// File: rtl/matrix_key_scan.sv
// Matrix keypad scanner with debounce, row scan, hold/release tracking and
// optional auto-repeat.
//
// Optional feature macro: KEY_REPEAT_EN (auto-repeat of key_vld while held).
//
// Ports:
//   clk       system clock
//   rst       synchronous active-high reset
//   key_col   column sense lines, active-low, asynchronous to clk
//   key_row   row drive, active-low
//   key_num   code of the last pressed key (row*COLS + col), held until next press
//   key_vld   one-cycle pulse, key_num valid
//   key_rel   one-cycle pulse on debounced release of the reported key
//   key_busy  high whenever the scanner is not idle
module matrix_key_scan #(
  parameter int unsigned ROWS          = 4,
  parameter int unsigned COLS          = 4,
  parameter int unsigned TIME_DEBOUNCE = 1000000,
  parameter int unsigned TIME_SCAN     = 50000,
  parameter int unsigned TIME_REP_DLY  = 25000000,
  parameter int unsigned TIME_REP_RATE = 5000000,
  localparam int unsigned NUM_W        = $clog2(ROWS * COLS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [COLS-1:0]  key_col,
  output logic [ROWS-1:0]  key_row,
  output logic [NUM_W-1:0] key_num,
  output logic             key_vld,
  output logic             key_rel,
  output logic             key_busy
);

  localparam int unsigned ROW_W    = $clog2(ROWS);
  localparam int unsigned COL_W    = $clog2(COLS);
  localparam int unsigned SCAN_LEN = TIME_SCAN + 2;
  localparam int unsigned CNT_MAX  = (TIME_DEBOUNCE > SCAN_LEN) ? TIME_DEBOUNCE : SCAN_LEN;
  localparam int unsigned CNT_W    = $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(TIME_DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_LEN - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(ROWS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StDebounce,
    StScan,
    StHold,
    StRelease
  } state_e;

  state_e             state_q, state_d;
  logic [COLS-1:0]    col_meta_q, col_s_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [NUM_W-1:0]   num_q, num_d;
  logic               vld_q, vld_d;
  logic               rel_q, rel_d;
  logic               col_idle;
  logic [COL_W-1:0]   hit_col;

`ifdef KEY_REPEAT_EN
  localparam int unsigned REP_MAX = (TIME_REP_DLY > TIME_REP_RATE) ? TIME_REP_DLY : TIME_REP_RATE;
  localparam int unsigned REP_W   = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;
  localparam logic [REP_W-1:0] DLY_LAST  = REP_W'(TIME_REP_DLY - 1);
  localparam logic [REP_W-1:0] RATE_LAST = REP_W'(TIME_REP_RATE - 1);

  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             rep_first_q, rep_first_d;
`endif

  assign col_idle = &col_s_q;

  // Lowest-index low column wins.
  always_comb begin
    hit_col = '0;
    for (int i = COLS - 1; i >= 0; i--) begin
      if (!col_s_q[i]) hit_col = COL_W'(i);
    end
  end

  always_comb begin
    key_row = '0;
    if (state_q == StScan || state_q == StHold || state_q == StRelease) begin
      key_row = ~(ROWS'(1) << row_q);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    col_d   = col_q;
    num_d   = num_q;
    vld_d   = 1'b0;
    rel_d   = 1'b0;
`ifdef KEY_REPEAT_EN
    rep_cnt_d   = rep_cnt_q;
    rep_first_d = rep_first_q;
`endif
    case (state_q)
      StIdle: begin
        if (!col_idle) begin
          state_d = StDebounce;
          cnt_d   = '0;
        end
      end
      StDebounce: begin
        if (col_idle) begin
          state_d = StIdle;
        end else if (cnt_q == DEB_LAST) begin
          state_d = StScan;
          cnt_d   = '0;
          row_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StScan: begin
        // Columns are sampled only on the last cycle of each row, after the
        // row drive has settled and crossed the synchronizer.
        if (cnt_q == SCAN_LAST) begin
          cnt_d = '0;
          if (!col_idle) begin
            state_d = StHold;
            col_d   = hit_col;
            num_d   = NUM_W'(int'(row_q) * int'(COLS) + int'(hit_col));
            vld_d   = 1'b1;
`ifdef KEY_REPEAT_EN
            rep_cnt_d   = '0;
            rep_first_d = 1'b1;
`endif
          end else if (row_q == ROW_LAST) begin
            state_d = StIdle;
          end else begin
            row_d = row_q + ROW_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StHold: begin
        if (col_s_q[col_q]) begin
          state_d = StRelease;
          cnt_d   = '0;
        end else begin
`ifdef KEY_REPEAT_EN
          if (rep_first_q ? (rep_cnt_q == DLY_LAST) : (rep_cnt_q == RATE_LAST)) begin
            vld_d       = 1'b1;
            rep_cnt_d   = '0;
            rep_first_d = 1'b0;
          end else begin
            rep_cnt_d = rep_cnt_q + REP_W'(1);
          end
`endif
        end
      end
      StRelease: begin
        if (!col_s_q[col_q]) begin
          state_d = StHold;
        end else if (cnt_q == DEB_LAST) begin
          state_d = StIdle;
          rel_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      col_meta_q <= '1;
      col_s_q    <= '1;
      cnt_q      <= '0;
      row_q      <= '0;
      col_q      <= '0;
      num_q      <= '0;
      vld_q      <= 1'b0;
      rel_q      <= 1'b0;
`ifdef KEY_REPEAT_EN
      rep_cnt_q   <= '0;
      rep_first_q <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      col_meta_q <= key_col;
      col_s_q    <= col_meta_q;
      cnt_q      <= cnt_d;
      row_q      <= row_d;
      col_q      <= col_d;
      num_q      <= num_d;
      vld_q      <= vld_d;
      rel_q      <= rel_d;
`ifdef KEY_REPEAT_EN
      rep_cnt_q   <= rep_cnt_d;
      rep_first_q <= rep_first_d;
`endif
    end
  end

  assign key_num  = num_q;
  assign key_vld  = vld_q;
  assign key_rel  = rel_q;
  assign key_busy = (state_q != StIdle);

endmodule
